// File: rtl/bf_io_buffer.sv
// bf_io_buffer: byte buffering between a control unit and a UART.
// TX path: CPU pushes bytes into a TX FIFO; a drain FSM (IDLE/LAUNCH/HOLD/DRAIN)
// pops one byte at a time and issues a single-cycle start pulse to the UART TX.
// RX path: UART RX strobes bytes into an RX FIFO read by the CPU (show-ahead).
// Optional local echo is enabled by defining BF_IO_ECHO_EN.
// Handshakes: cpu_tx_start_i pushes on any cycle the TX FIFO is not full
// (cpu_tx_busy_o); an RX byte is popped on a cycle where cpu_rx_valid_o and
// cpu_rx_ready_i are both high; uart_rx_valid_i is a one-cycle strobe that is
// never back-pressured (bytes that find the FIFO full are dropped and flagged).
module bf_io_buffer #(
  parameter int TX_DEPTH_LOG2 = 2,
  parameter int RX_DEPTH_LOG2 = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               cpu_tx_byte_i,
  input  logic                     cpu_tx_start_i,
  output logic                     cpu_tx_busy_o,
  output logic [7:0]               cpu_rx_byte_o,
  output logic                     cpu_rx_valid_o,
  input  logic                     cpu_rx_ready_i,
  output logic [7:0]               uart_tx_data_o,
  output logic                     uart_tx_start_o,
  input  logic                     uart_tx_busy_i,
  input  logic [7:0]               uart_rx_data_i,
  input  logic                     uart_rx_valid_i,
  output logic [TX_DEPTH_LOG2:0]   tx_level_o,
  output logic [RX_DEPTH_LOG2:0]   rx_level_o,
  output logic                     rx_overflow_o,
  input  logic                     clr_ovf_i
);

  localparam int TXD = 1 << TX_DEPTH_LOG2;
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0]   TX_FULL    = (TX_DEPTH_LOG2+1)'(TXD);
  localparam logic [RX_DEPTH_LOG2:0]   RX_FULL    = (RX_DEPTH_LOG2+1)'(RXD);
  localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE = (TX_DEPTH_LOG2+1)'(1);
  localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE = (RX_DEPTH_LOG2+1)'(1);
  localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE = TX_DEPTH_LOG2'(1);
  localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE = RX_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_HOLD, S_DRAIN} state_t;

  logic [7:0]               r_tx_mem [TXD];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
  logic [TX_DEPTH_LOG2:0]   r_tx_cnt;
  logic [7:0]               r_rx_mem [RXD];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
  logic [RX_DEPTH_LOG2:0]   r_rx_cnt;
  state_t                   r_state;
  logic                     r_tx_start;
  logic [7:0]               r_tx_data;
  logic                     r_ovf;

  logic       w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0] w_tx_din;
  logic       w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_ovf_set;

  assign w_tx_full  = (r_tx_cnt == TX_FULL);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_FULL);
  assign w_rx_empty = (r_rx_cnt == '0);

  // RX: a pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
  assign w_rx_pop  = !w_rx_empty && cpu_rx_ready_i;
  assign w_rx_push = uart_rx_valid_i && (!w_rx_full || w_rx_pop);
  assign w_ovf_set = uart_rx_valid_i && w_rx_full && !w_rx_pop;

`ifdef BF_IO_ECHO_EN
  // Echo only fills a TX slot the CPU is not using this cycle.
  logic w_echo;
  assign w_echo    = w_rx_push && !cpu_tx_start_i && !w_tx_full;
  assign w_tx_push = (cpu_tx_start_i && !w_tx_full) || w_echo;
  assign w_tx_din  = cpu_tx_start_i ? cpu_tx_byte_i : uart_rx_data_i;
`else
  assign w_tx_push = cpu_tx_start_i && !w_tx_full;
  assign w_tx_din  = cpu_tx_byte_i;
`endif

  // The drain FSM pops the head only from IDLE with the UART idle.
  assign w_tx_pop = (r_state == S_IDLE) && !w_tx_empty && !uart_tx_busy_i;

  // TX storage: data array carries no reset, emptiness comes from the count.
  always_ff @(posedge clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= w_tx_din;
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // Drain FSM: launch one byte, hold a cycle for UART busy latency, wait out busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tx_pop) begin
            r_state    <= S_LAUNCH;
            r_tx_start <= 1'b1;
            r_tx_data  <= r_tx_mem[r_tx_rptr];
          end
        end
        S_LAUNCH: r_state <= S_HOLD;
        S_HOLD:   r_state <= S_DRAIN;
        S_DRAIN:  if (!uart_tx_busy_i) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // RX storage.
  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_rx_data_i;
  end

  // RX pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // Sticky overflow flag; a clear wins over a same-cycle drop.
  always_ff @(posedge clk_i) begin
    if (rst_i)          r_ovf <= 1'b0;
    else if (clr_ovf_i) r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
  end

  assign cpu_tx_busy_o   = w_tx_full;
  assign cpu_rx_byte_o   = r_rx_mem[r_rx_rptr];
  assign cpu_rx_valid_o  = !w_rx_empty;
  assign uart_tx_data_o  = r_tx_data;
  assign uart_tx_start_o = r_tx_start;
  assign tx_level_o      = r_tx_cnt;
  assign rx_level_o      = r_rx_cnt;
  assign rx_overflow_o   = r_ovf;

endmodule

// File: tb/tb_bf_io_buffer.sv
// Testbench for bf_io_buffer (default depths of 4). Directed scenarios plus a
// randomized run checked against a queue-based model of both FIFOs. The echo
// scenario is compiled in when BF_IO_ECHO_EN is defined.
module tb_bf_io_buffer;
  localparam int TXD = 4;
  localparam int RXD = 4;

  // ---------------- clock / reset ----------------
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] cpu_tx_byte_i = 8'h00;
  logic       cpu_tx_start_i = 1'b0;
  logic       cpu_tx_busy_o;
  logic [7:0] cpu_rx_byte_o;
  logic       cpu_rx_valid_o;
  logic       cpu_rx_ready_i = 1'b0;
  logic [7:0] uart_tx_data_o;
  logic       uart_tx_start_o;
  logic       uart_tx_busy_i = 1'b0;
  logic [7:0] uart_rx_data_i = 8'h00;
  logic       uart_rx_valid_i = 1'b0;
  logic [2:0] tx_level_o;
  logic [2:0] rx_level_o;
  logic       rx_overflow_o;
  logic       clr_ovf_i = 1'b0;

  always #5 clk_i = ~clk_i;

  bf_io_buffer #(.TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_tx_byte_i(cpu_tx_byte_i), .cpu_tx_start_i(cpu_tx_start_i), .cpu_tx_busy_o(cpu_tx_busy_o),
    .cpu_rx_byte_o(cpu_rx_byte_o), .cpu_rx_valid_o(cpu_rx_valid_o), .cpu_rx_ready_i(cpu_rx_ready_i),
    .uart_tx_data_o(uart_tx_data_o), .uart_tx_start_o(uart_tx_start_o), .uart_tx_busy_i(uart_tx_busy_i),
    .uart_rx_data_i(uart_rx_data_i), .uart_rx_valid_i(uart_rx_valid_i),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
    .rx_overflow_o(rx_overflow_o), .clr_ovf_i(clr_ovf_i)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];     // bytes accepted into TX, not yet launched
  logic [7:0] rx_q[$];      // RX FIFO contents
  logic       exp_ovf = 1'b0;
  int         busy_cnt = 0;
  int         busy_len = 0;
  logic       hold_busy = 1'b0;
  logic       got_start = 1'b0;
  logic       start_unexp = 1'b0;
  logic [7:0] obs_launch = 8'h00;
  logic [7:0] exp_launch = 8'h00;
  logic [7:0] last_data = 8'h00;
  int         since_start = 100;
  int         gap = 100;
  logic       rx_popped = 1'b0;
  logic [7:0] obs_pop = 8'h00;
  logic [7:0] exp_pop = 8'h00;

  // ---------------- driver tasks ----------------
  // One clock cycle: update the model for the coming edge, drive inputs,
  // clock, then record any start pulse seen after the edge.
  task automatic step(input logic tx_go, input logic [7:0] tx_b, input logic rx_go,
                      input logic [7:0] rx_b, input logic rdy, input logic clr);
    int tsz;
    int rsz;
    logic rpop;
    logic rpush;
    tsz = exp_q.size();
    rsz = rx_q.size();
    rpop  = rdy && (rsz > 0);
    rpush = rx_go && ((rsz < RXD) || rpop);
    rx_popped = rpop;
    if (rpop) begin
      obs_pop = cpu_rx_byte_o;
      exp_pop = rx_q.pop_front();
    end
    if (rpush) rx_q.push_back(rx_b);
    if (clr) exp_ovf = 1'b0;
    else if (rx_go && !rpush) exp_ovf = 1'b1;
    if (tx_go && (tsz < TXD)) exp_q.push_back(tx_b);
`ifdef BF_IO_ECHO_EN
    else if (!tx_go && rpush && (tsz < TXD)) exp_q.push_back(rx_b);
`endif
    cpu_tx_start_i  = tx_go;
    cpu_tx_byte_i   = tx_b;
    uart_rx_valid_i = rx_go;
    uart_rx_data_i  = rx_b;
    cpu_rx_ready_i  = rdy;
    clr_ovf_i       = clr;
    uart_tx_busy_i  = hold_busy || (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    @(posedge clk_i);
    #1;
    got_start   = uart_tx_start_o;
    start_unexp = 1'b0;
    if (got_start) begin
      gap = since_start + 1;
      since_start = 0;
      busy_cnt = busy_len;
      obs_launch = uart_tx_data_o;
      if (exp_q.size() == 0) start_unexp = 1'b1;
      else begin
        exp_launch = exp_q.pop_front();
        last_data  = exp_launch;
      end
    end else begin
      since_start++;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic settle(input int n);
    repeat (n) idle_step();
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    cpu_tx_start_i = 1'b0; uart_rx_valid_i = 1'b0; cpu_rx_ready_i = 1'b0; clr_ovf_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete(); rx_q.delete();
    exp_ovf = 1'b0; last_data = 8'h00; since_start = 100; got_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if (uart_tx_start_o !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", uart_tx_start_o); end
    total++; if (uart_tx_data_o !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", uart_tx_data_o); end
    total++; if (rx_overflow_o !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", rx_overflow_o); end
    total++; if (tx_level_o !== 3'd0) begin bad++; $display("FAIL rst_txlvl got=%0d exp=0", tx_level_o); end
    total++; if (rx_level_o !== 3'd0) begin bad++; $display("FAIL rst_rxlvl got=%0d exp=0", rx_level_o); end
    total++; if (cpu_rx_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rxvalid got=%b exp=0", cpu_rx_valid_o); end
    total++; if (cpu_tx_busy_o !== 1'b0) begin bad++; $display("FAIL rst_txbusy got=%b exp=0", cpu_tx_busy_o); end
    apply_reset();
  endtask

  task automatic test_tx_latency();
    busy_len = 3;
    step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (got_start !== 1'b0) begin bad++; $display("FAIL lat_early got=%b exp=0", got_start); end
    total++; if (tx_level_o !== 3'd1) begin bad++; $display("FAIL lat_level got=%0d exp=1", tx_level_o); end
    idle_step();
    total++; if (got_start !== 1'b1) begin bad++; $display("FAIL lat_start got=%b exp=1", got_start); end
    total++; if (uart_tx_data_o !== 8'h5A) begin bad++; $display("FAIL lat_data got=%h exp=5a", uart_tx_data_o); end
    idle_step();
    total++; if (got_start !== 1'b0) begin bad++; $display("FAIL lat_pulse_width got=%b exp=0", got_start); end
    settle(12);
  endtask

  task automatic test_tx_burst();
    logic [7:0] burst [3];
    int cnt;
    burst[0] = 8'h41; burst[1] = 8'h42; burst[2] = 8'h43;
    busy_len = 20;
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, burst[i], 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (tx_level_o !== 3'd3) begin bad++; $display("FAIL burst_level3 got=%0d exp=3", tx_level_o); end
    hold_busy = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 3; c++) begin
      idle_step();
      if (got_start) begin
        total++;
        if (start_unexp || obs_launch !== burst[cnt]) begin
          bad++; $display("FAIL burst_data idx=%0d got=%h exp=%h", cnt, obs_launch, burst[cnt]);
        end
        cnt++;
      end
    end
    total++; if (cnt != 3) begin bad++; $display("FAIL burst_count got=%0d exp=3", cnt); end
    total++; if (tx_level_o !== 3'd0) begin bad++; $display("FAIL burst_level0 got=%0d exp=0", tx_level_o); end
    settle(30);
  endtask

  task automatic test_tx_full();
    int cnt;
    hold_busy = 1'b1;
    busy_len = 2;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0, 1'b0);
      total++;
      if (cpu_tx_busy_o !== (i >= 3)) begin bad++; $display("FAIL full_busy push=%0d got=%b exp=%b", i, cpu_tx_busy_o, (i >= 3)); end
    end
    total++; if (tx_level_o !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", tx_level_o); end
    hold_busy = 1'b0;
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      idle_step();
      if (got_start) begin
        total++;
        if (start_unexp || cnt > 3 || obs_launch !== 8'(8'h60 + cnt)) begin
          bad++; $display("FAIL full_data idx=%0d got=%h exp=%h", cnt, obs_launch, 8'(8'h60 + cnt));
        end
        cnt++;
      end
    end
    total++; if (cnt != 4) begin bad++; $display("FAIL full_count got=%0d exp=4", cnt); end
    total++; if (tx_level_o !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d exp=0", tx_level_o); end
  endtask

  task automatic test_rx_overflow();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    total++; if (rx_level_o !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", rx_level_o); end
    total++; if (rx_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", rx_overflow_o); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cpu_rx_byte_o !== 8'(8'h10 + i)) begin bad++; $display("FAIL ovf_pop idx=%0d got=%h exp=%h", i, cpu_rx_byte_o, 8'(8'h10 + i)); end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    total++; if (cpu_rx_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", cpu_rx_valid_o); end
    total++; if (rx_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", rx_overflow_o); end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (rx_overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", rx_overflow_o); end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h24, 1'b0, 1'b1);
    total++; if (rx_overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clr_priority got=%b exp=0", rx_overflow_o); end
    total++; if (rx_level_o !== 3'd4) begin bad++; $display("FAIL ovf_clr_level got=%0d exp=4", rx_level_o); end
    repeat (4) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_rx_full_push_pop();
    logic [7:0] order [4];
    order[0] = 8'hA1; order[1] = 8'hA2; order[2] = 8'hA3; order[3] = 8'h55;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0);
    total++; if (rx_level_o !== 3'd4) begin bad++; $display("FAIL pp_level got=%0d exp=4", rx_level_o); end
    total++; if (rx_overflow_o !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", rx_overflow_o); end
    total++; if (obs_pop !== 8'hA0) begin bad++; $display("FAIL pp_first got=%h exp=a0", obs_pop); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cpu_rx_byte_o !== order[i]) begin bad++; $display("FAIL pp_order idx=%0d got=%h exp=%h", i, cpu_rx_byte_o, order[i]); end
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 8'h66, 1'b1, 1'b0);
    total++; if (rx_level_o !== 3'd1) begin bad++; $display("FAIL pp_empty_level got=%0d exp=1", rx_level_o); end
    total++; if (cpu_rx_byte_o !== 8'h66) begin bad++; $display("FAIL pp_empty_byte got=%h exp=66", cpu_rx_byte_o); end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    int cnt;
    busy_len = 20;
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h71 + i), 1'b0, 8'h00, 1'b0, 1'b0);
    settle(4);
    total++; if (tx_level_o !== 3'd2) begin bad++; $display("FAIL mid_level got=%0d exp=2", tx_level_o); end
    apply_reset();
    total++; if (tx_level_o !== 3'd0) begin bad++; $display("FAIL mid_txlvl got=%0d exp=0", tx_level_o); end
    total++; if (rx_level_o !== 3'd0) begin bad++; $display("FAIL mid_rxlvl got=%0d exp=0", rx_level_o); end
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      idle_step();
      if (got_start) cnt++;
    end
    total++; if (cnt != 0) begin bad++; $display("FAIL mid_restart got=%0d exp=0", cnt); end
  endtask

  task automatic test_random();
    logic tg, rg, rd, cl;
    logic [7:0] tb_b, rb;
    logic [2:0] e_tl, e_rl;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 15) == 0) busy_len = $urandom_range(0, 6);
      tg = ($urandom_range(0, 2) == 0);
      rg = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 0);
      cl = ($urandom_range(0, 19) == 0);
      tb_b = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      step(tg, tb_b, rg, rb, rd, cl);
      if (got_start) begin
        total++; if (start_unexp) begin bad++; $display("FAIL rnd_unexpected_start cyc=%0d got=1 exp=0", c); end
        total++; if (obs_launch !== exp_launch) begin bad++; $display("FAIL rnd_tx_data cyc=%0d got=%h exp=%h", c, obs_launch, exp_launch); end
        total++; if (gap < 4) begin bad++; $display("FAIL rnd_start_gap cyc=%0d got=%0d exp>=4", c, gap); end
      end else begin
        total++; if (uart_tx_data_o !== last_data) begin bad++; $display("FAIL rnd_tx_stable cyc=%0d got=%h exp=%h", c, uart_tx_data_o, last_data); end
      end
      e_tl = 3'(exp_q.size());
      e_rl = 3'(rx_q.size());
      total++; if (tx_level_o !== e_tl) begin bad++; $display("FAIL rnd_txlvl cyc=%0d got=%0d exp=%0d", c, tx_level_o, e_tl); end
      total++; if (cpu_tx_busy_o !== (e_tl == 3'd4)) begin bad++; $display("FAIL rnd_txbusy cyc=%0d got=%b exp=%b", c, cpu_tx_busy_o, (e_tl == 3'd4)); end
      total++; if (rx_level_o !== e_rl) begin bad++; $display("FAIL rnd_rxlvl cyc=%0d got=%0d exp=%0d", c, rx_level_o, e_rl); end
      total++; if (cpu_rx_valid_o !== (e_rl != 3'd0)) begin bad++; $display("FAIL rnd_rxvalid cyc=%0d got=%b exp=%b", c, cpu_rx_valid_o, (e_rl != 3'd0)); end
      if (e_rl != 3'd0) begin
        total++; if (cpu_rx_byte_o !== rx_q[0]) begin bad++; $display("FAIL rnd_rxhead cyc=%0d got=%h exp=%h", c, cpu_rx_byte_o, rx_q[0]); end
      end
      if (rx_popped) begin
        total++; if (obs_pop !== exp_pop) begin bad++; $display("FAIL rnd_rxpop cyc=%0d got=%h exp=%h", c, obs_pop, exp_pop); end
      end
      total++; if (rx_overflow_o !== exp_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, rx_overflow_o, exp_ovf); end
    end
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      idle_step();
      if (got_start) begin
        total++; if (start_unexp || obs_launch !== exp_launch) begin bad++; $display("FAIL rnd_drain_data got=%h exp=%h", obs_launch, exp_launch); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain_timeout got=%0d exp=0", exp_q.size()); end
    settle(12);
    repeat (RXD) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

`ifdef BF_IO_ECHO_EN
  task automatic test_echo();
    int cnt;
    busy_len = 3;
    step(1'b0, 8'h00, 1'b1, 8'h7A, 1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 10 && cnt == 0; c++) begin
      idle_step();
      if (got_start) begin
        cnt++;
        total++; if (obs_launch !== 8'h7A) begin bad++; $display("FAIL echo_data got=%h exp=7a", obs_launch); end
      end
    end
    total++; if (cnt != 1) begin bad++; $display("FAIL echo_start got=%0d exp=1", cnt); end
    settle(10);
    step(1'b1, 8'h01, 1'b1, 8'h7B, 1'b0, 1'b0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      idle_step();
      if (got_start) begin
        cnt++;
        total++; if (obs_launch !== 8'h01) begin bad++; $display("FAIL echo_cpu_prio got=%h exp=01", obs_launch); end
      end
    end
    total++; if (cnt != 1) begin bad++; $display("FAIL echo_cpu_count got=%0d exp=1", cnt); end
    total++; if (cpu_rx_byte_o !== 8'h7A) begin bad++; $display("FAIL echo_rx0 got=%h exp=7a", cpu_rx_byte_o); end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    total++; if (cpu_rx_byte_o !== 8'h7B) begin bad++; $display("FAIL echo_rx1 got=%h exp=7b", cpu_rx_byte_o); end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_tx_latency();
    test_tx_burst();
    test_tx_full();
    test_rx_overflow();
    test_rx_full_push_pop();
    test_reset_mid_drain();
    test_random();
`ifdef BF_IO_ECHO_EN
    test_echo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_io_buffer.md
BF_IO_BUFFER -- requirements
Module: bf_io_buffer

Interface
REQ-001 SHALL have parameter TX_DEPTH_LOG2, default 2, meaning TX FIFO holds 2**TX_DEPTH_LOG2 bytes; legal range 1..6.
REQ-002 SHALL have parameter RX_DEPTH_LOG2, default 2, meaning RX FIFO holds 2**RX_DEPTH_LOG2 bytes; legal range 1..6.
REQ-003 SHALL have ports, clock and reset first:
- clk_i  input  1  single clock; all logic on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- cpu_tx_byte_i  input  8  byte from the control unit to transmit.
- cpu_tx_start_i  input  1  push strobe for cpu_tx_byte_i.
- cpu_tx_busy_o  output  1  high while TX FIFO is full.
- cpu_rx_byte_o  output  8  RX FIFO head byte (show-ahead).
- cpu_rx_valid_o  output  1  RX FIFO non-empty.
- cpu_rx_ready_i  input  1  pop strobe for RX FIFO.
- uart_tx_data_o  output  8  byte presented to UART TX.
- uart_tx_start_o  output  1  one-cycle start pulse to UART TX.
- uart_tx_busy_i  input  1  UART TX shifting.
- uart_rx_data_i  input  8  byte from UART RX.
- uart_rx_valid_i  input  1  one-cycle received-byte strobe.
- tx_level_o  output  TX_DEPTH_LOG2+1  TX FIFO occupancy.
- rx_level_o  output  RX_DEPTH_LOG2+1  RX FIFO occupancy.
- rx_overflow_o  output  1  sticky RX overflow flag.
- clr_ovf_i  input  1  clears rx_overflow_o.

Function
REQ-004 TX push SHALL occur when cpu_tx_start_i=1 and TX FIFO not full; a push while full SHALL be ignored, with no state change.
REQ-005 TX drain FSM SHALL have states IDLE, LAUNCH, HOLD, DRAIN.
REQ-006 IDLE->LAUNCH SHALL occur when the FIFO is non-empty and uart_tx_busy_i=0; the head byte SHALL be registered to uart_tx_data_o and popped on that edge.
REQ-007 In LAUNCH, uart_tx_start_o SHALL be 1 for exactly one cycle; the FSM SHALL then enter HOLD unconditionally.
REQ-008 HOLD SHALL last one cycle, covering UART busy latency, then enter DRAIN.
REQ-009 DRAIN->IDLE SHALL occur on the first cycle with uart_tx_busy_i=0.
REQ-010 uart_tx_data_o SHALL stay stable from LAUNCH until the next IDLE->LAUNCH.
REQ-011 Latency: push at edge n with FIFO empty, FSM in IDLE and UART idle SHALL give uart_tx_start_o=1 in the cycle after edge n+1.
REQ-012 RX push SHALL occur when uart_rx_valid_i=1.
- If the RX FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and rx_overflow_o set.
REQ-013 RX pop SHALL occur when cpu_rx_valid_o=1 and cpu_rx_ready_i=1; ready while empty SHALL be ignored.
REQ-014 Simultaneous RX push and pop when full SHALL accept both: level unchanged, no overflow.
- Simultaneous push and pop when empty SHALL leave the new byte stored, level 1.
REQ-015 Simultaneous TX push and FSM pop SHALL leave tx_level_o unchanged.
REQ-016 Pointers SHALL wrap modulo depth; levels SHALL saturate at neither bound, since push-when-full and pop-when-empty are blocked.
REQ-017 rx_overflow_o SHALL clear on clr_ovf_i.
- clr_ovf_i SHALL take priority over a same-cycle overflow set.
REQ-018 FIFO order SHALL be strictly first-in first-out on both paths.

Reset
REQ-019 On rst_i=1 at an edge, both FIFOs SHALL empty and the FSM SHALL go to IDLE.
REQ-020 Output values in reset:
- uart_tx_start_o=0, uart_tx_data_o=0x00, rx_overflow_o=0.
- tx_level_o=0, rx_level_o=0, cpu_rx_valid_o=0, cpu_tx_busy_o=0.
REQ-021 Reset mid-transmission (LAUNCH/HOLD/DRAIN) SHALL abort to IDLE, discard queued bytes, and not re-issue uart_tx_start_o.

Configuration
REQ-022 Macro BF_IO_ECHO_EN SHALL select local echo.
- Defined: each accepted RX byte SHALL also be pushed into the TX FIFO, if the TX FIFO is not full and cpu_tx_start_i=0 that cycle; otherwise the echo is silently skipped. CPU push has priority.
- Undefined: no echo logic is present; TX FIFO is fed only by the CPU.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- TX burst: push 0x41,0x42,0x43 on consecutive cycles, UART busy modelled 20 cycles -> three start pulses, data 0x41,0x42,0x43 in order; tx_level_o 3->0.
- TX full: depth 4, UART busy held high, push 5 bytes -> cpu_tx_busy_o=1 after 4th; 5th byte never appears; tx_level_o=4.
- RX overflow: depth 4, 5 rx strobes 0x10..0x14, no pops -> rx_level_o=4, rx_overflow_o=1, pops return 0x10..0x13; clr_ovf_i -> flag 0.
- RX full push+pop same cycle: full FIFO, strobe 0x55 with ready=1 -> level stays 4, no overflow, 0x55 last out.
- Reset mid-DRAIN with 2 queued -> levels 0, no further uart_tx_start_o.
- BF_IO_ECHO_EN defined: rx 0x7A -> uart_tx_data_o=0x7A start pulse; rx 0x7B same cycle as CPU push 0x01 -> only 0x01 transmitted.
